// File: rtl/alt_lutk_bank_pkg.sv
// Shared types and sizing helpers for the alt_lutk_bank LUT bank.
package alt_lutk_bank_pkg;

  // Address width for a table of n entries; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SWAP  = 2'd2
  } cfg_state_e;

  // Default geometry used by the interface and top when not overridden.
  localparam int NUM_CH_DEF = 4;
  localparam int K_DEF      = 6;
  localparam int CFG_W_DEF  = 16;
  localparam int MASK_W     = 1 << K_DEF;
  localparam int WPC        = MASK_W / CFG_W_DEF;
  localparam int CH_AW      = addr_w(NUM_CH_DEF);
  localparam int WD_AW      = addr_w(WPC);

endpackage

// File: rtl/alt_lutk_bank_if.sv
// Lookup and configuration bus of the LUT bank.
interface alt_lutk_bank_if
  import alt_lutk_bank_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int K      = K_DEF,
  parameter int CFG_W  = CFG_W_DEF
);
  localparam int CAW = addr_w(NUM_CH);
  localparam int WAW = addr_w((1 << K) / CFG_W);

  logic                  in_valid;
  logic [NUM_CH*K-1:0]   din;
  logic                  out_valid;
  logic [NUM_CH-1:0]     dout;
  logic                  cfg_wr;
  logic [CAW-1:0]        cfg_ch;
  logic [WAW-1:0]        cfg_word;
  logic [CFG_W-1:0]      cfg_data;
  logic                  cfg_commit;
  logic                  cfg_busy;
  logic                  cfg_ack;
  logic                  cfg_err;

  modport master (
    output in_valid, din, cfg_wr, cfg_ch, cfg_word, cfg_data, cfg_commit,
    input  out_valid, dout, cfg_busy, cfg_ack, cfg_err
  );

  modport slave (
    input  in_valid, din, cfg_wr, cfg_ch, cfg_word, cfg_data, cfg_commit,
    output out_valid, dout, cfg_busy, cfg_ack, cfg_err
  );

endinterface

// File: rtl/alt_lutk_bank_cell.sv
// One LUT channel: double-buffered mask (shadow written word by word,
// copied to active on swap) and the K-bit index mux on the active mask.
module alt_lutk_cell #(
  parameter int K     = 6,
  parameter int CFG_W = 16,
  parameter int WAW   = 2,
  parameter logic [(1<<K)-1:0] INIT_MASK = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [WAW-1:0]   word_i,
  input  logic [CFG_W-1:0] data_i,
  input  logic             swap_i,
  input  logic [K-1:0]     idx_i,
  output logic             bit_o
);
  localparam int MW = 1 << K;

  logic [MW-1:0] active_q, active_d;
  logic [MW-1:0] shadow_q, shadow_d;

  // Next-state: one CFG_W slice of the shadow per write, whole-mask copy on swap.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_i) begin
      shadow_d[int'(word_i)*CFG_W +: CFG_W] = data_i;
    end
    if (swap_i) begin
      active_d = shadow_q;
    end
  end

  // Mask registers; both buffers restart from the reset mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= INIT_MASK;
      shadow_q <= INIT_MASK;
    end else begin
      active_q <= active_d;
      shadow_q <= shadow_d;
    end
  end

  assign bit_o = active_q[idx_i];

endmodule

// File: rtl/alt_lutk_bank.sv
// Bank of NUM_CH K-input LUTs with runtime-reprogrammable masks, a LAT-deep
// valid/data pipeline and an atomic shadow->active commit sequencer.
module alt_lutk_bank
  import alt_lutk_bank_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int K      = K_DEF,
  parameter int CFG_W  = CFG_W_DEF,
  parameter int LAT    = 2,
  parameter logic [(1<<K)-1:0] INIT_MASK = 64'h8000_0000_0000_0000,
  parameter bit SAFE_COMMIT = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  alt_lutk_bank_if.slave bus
);
  localparam int MW   = 1 << K;
  localparam int NWPC = MW / CFG_W;
  localparam int WAW  = addr_w(NWPC);

  if (K < 1 || K > 8) begin : g_bad_k
    $error("alt_lutk_bank: K must be in 1..8");
  end
  if (LAT < 1 || LAT > 4) begin : g_bad_lat
    $error("alt_lutk_bank: LAT must be in 1..4");
  end
  if ((MW % CFG_W) != 0) begin : g_bad_cfgw
    $error("alt_lutk_bank: CFG_W must divide 2^K");
  end

  cfg_state_e state_q, state_d;
  logic busy, ch_ok, wd_ok, wr_en, swap;
  logic ack_q, err_q, err_d;
  logic [NUM_CH-1:0] lut_bits;
  logic              vld_q [LAT];
  logic [NUM_CH-1:0] dat_q [LAT];

  assign busy  = (state_q != IDLE);
  assign ch_ok = (int'(bus.cfg_ch) < NUM_CH);
  assign wd_ok = (int'(bus.cfg_word) < NWPC);
  assign wr_en = bus.cfg_wr && !busy && ch_ok && wd_ok;

  // Any config request while a commit is in flight, or a write to a
  // nonexistent channel/word, latches the error flag until reset.
  assign err_d = err_q
               | (busy && (bus.cfg_wr || bus.cfg_commit))
               | (bus.cfg_wr && !busy && !(ch_ok && wd_ok));

  // Commit sequencer next-state; the swap strobe is asserted for the SWAP cycle.
  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    unique case (state_q)
      IDLE:    if (bus.cfg_commit) state_d = ARMED;
      ARMED:   if (!SAFE_COMMIT || !bus.in_valid) state_d = SWAP;
      SWAP: begin
        swap    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: sequencer, commit acknowledge and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= swap;
      err_q   <= err_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    alt_lutk_cell #(
      .K        (K),
      .CFG_W    (CFG_W),
      .WAW      (WAW),
      .INIT_MASK(INIT_MASK)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_i  (wr_en && (int'(bus.cfg_ch) == c)),
      .word_i(bus.cfg_word),
      .data_i(bus.cfg_data),
      .swap_i(swap),
      .idx_i (bus.din[c*K +: K]),
      .bit_o (lut_bits[c])
    );
  end

  // Stage 1: capture looked-up bits; data only moves with a valid lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q[0] <= 1'b0;
      dat_q[0] <= '0;
    end else begin
      vld_q[0] <= bus.in_valid;
      if (bus.in_valid) dat_q[0] <= lut_bits;
    end
  end

  for (genvar s = 1; s < LAT; s++) begin : g_dly
    // Stages 2..LAT: pure delay, bubbles leave the held data untouched.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q[s] <= 1'b0;
        dat_q[s] <= '0;
      end else begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
      end
    end
  end

  assign bus.out_valid = vld_q[LAT-1];
  assign bus.dout      = dat_q[LAT-1];
  assign bus.cfg_busy  = busy;
  assign bus.cfg_ack   = ack_q;
  assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_alt_lutk_bank.sv
// Directed bench for alt_lutk_bank (NUM_CH=4, K=6, CFG_W=16, LAT=2).
module tb_alt_lutk_bank;
  localparam int NUM_CH = 4;
  localparam int K      = 6;
  localparam int CFG_W  = 16;
  localparam int LAT    = 2;

  logic clk;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  alt_lutk_bank_if #(.NUM_CH(NUM_CH), .K(K), .CFG_W(CFG_W)) bm ();
  alt_lutk_bank_if #(.NUM_CH(NUM_CH), .K(K), .CFG_W(CFG_W)) bs ();

  alt_lutk_bank #(.NUM_CH(NUM_CH), .K(K), .CFG_W(CFG_W), .LAT(LAT),
                  .INIT_MASK(64'h8000_0000_0000_0000), .SAFE_COMMIT(1'b0))
    dut (.clk(clk), .rst_n(rst_n), .bus(bm));

  alt_lutk_bank #(.NUM_CH(NUM_CH), .K(K), .CFG_W(CFG_W), .LAT(LAT),
                  .INIT_MASK(64'h8000_0000_0000_0000), .SAFE_COMMIT(1'b1))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bm.in_valid = 0; bm.din = '0; bm.cfg_wr = 0; bm.cfg_ch = '0;
    bm.cfg_word = '0; bm.cfg_data = '0; bm.cfg_commit = 0;
    bs.in_valid = 0; bs.din = '0; bs.cfg_wr = 0; bs.cfg_ch = '0;
    bs.cfg_word = '0; bs.cfg_data = '0; bs.cfg_commit = 0;
  endtask

  task automatic wr_m(input int ch, input int w, input logic [15:0] data);
    bm.cfg_wr = 1; bm.cfg_ch = 2'(ch); bm.cfg_word = 2'(w); bm.cfg_data = data;
    tick();
    bm.cfg_wr = 0;
  endtask

  task automatic commit_m();
    bm.cfg_commit = 1;
    tick();
    bm.cfg_commit = 0;
    tick(); tick(); tick();
  endtask

  task automatic lookup_m(input logic [23:0] d, output logic v, output logic [3:0] q);
    bm.in_valid = 1; bm.din = d;
    tick();
    bm.in_valid = 0;
    tick();
    v = bm.out_valid; q = bm.dout;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    n_total++; if (bm.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", bm.out_valid); else n_pass++;
    n_total++; if (bm.dout !== 4'b0000) $display("FAIL rst_dout got=%b want=0000", bm.dout); else n_pass++;
    n_total++; if (bm.cfg_busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", bm.cfg_busy); else n_pass++;
    n_total++; if (bm.cfg_ack !== 1'b0) $display("FAIL rst_ack got=%b want=0", bm.cfg_ack); else n_pass++;
    n_total++; if (bm.cfg_err !== 1'b0) $display("FAIL rst_err got=%b want=0", bm.cfg_err); else n_pass++;
    rst_n = 1;
    tick();
  endtask

  task automatic test_lookup();
    logic v; logic [3:0] q;
    bm.in_valid = 1; bm.din = 24'h00003F;
    tick();
    n_total++; if (bm.out_valid !== 1'b0) $display("FAIL lk_lat1 got=%b want=0", bm.out_valid); else n_pass++;
    bm.in_valid = 0;
    tick();
    n_total++; if (bm.out_valid !== 1'b1) $display("FAIL lk_lat2_vld got=%b want=1", bm.out_valid); else n_pass++;
    n_total++; if (bm.dout !== 4'b0001) $display("FAIL lk_ch0_63 got=%b want=0001", bm.dout); else n_pass++;
    tick();
    n_total++; if (bm.out_valid !== 1'b0) $display("FAIL lk_bubble got=%b want=0", bm.out_valid); else n_pass++;
    n_total++; if (bm.dout !== 4'b0001) $display("FAIL lk_hold got=%b want=0001", bm.dout); else n_pass++;
    lookup_m(24'hFFFFFF, v, q);
    n_total++; if (q !== 4'b1111) $display("FAIL lk_all63 got=%b want=1111", q); else n_pass++;
    lookup_m({4{6'h3E}}, v, q);
    n_total++; if (q !== 4'b0000) $display("FAIL lk_all62 got=%b want=0000", q); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bm.in_valid = 1; bm.din = 24'h00003F;
    tick();
    bm.din = 24'hFC0000;
    tick();
    bm.in_valid = 0;
    n_total++; if (bm.dout !== 4'b0001) $display("FAIL b2b_first got=%b want=0001", bm.dout); else n_pass++;
    tick();
    n_total++; if (bm.out_valid !== 1'b1) $display("FAIL b2b_vld got=%b want=1", bm.out_valid); else n_pass++;
    n_total++; if (bm.dout !== 4'b1000) $display("FAIL b2b_second got=%b want=1000", bm.dout); else n_pass++;
  endtask

  task automatic test_commit();
    wr_m(2, 0, 16'h0001);
    wr_m(2, 1, 16'h0000);
    wr_m(2, 2, 16'h0000);
    wr_m(2, 3, 16'h0000);
    bm.cfg_commit = 1; bm.in_valid = 1; bm.din = '0;
    tick();
    bm.cfg_commit = 0;
    n_total++; if (bm.cfg_busy !== 1'b1) $display("FAIL cm_busy_armed got=%b want=1", bm.cfg_busy); else n_pass++;
    tick();
    n_total++; if (bm.cfg_busy !== 1'b1) $display("FAIL cm_busy_swap got=%b want=1", bm.cfg_busy); else n_pass++;
    n_total++; if (bm.dout !== 4'b0000) $display("FAIL cm_old0 got=%b want=0000", bm.dout); else n_pass++;
    tick();
    n_total++; if (bm.cfg_ack !== 1'b1) $display("FAIL cm_ack got=%b want=1", bm.cfg_ack); else n_pass++;
    n_total++; if (bm.cfg_busy !== 1'b0) $display("FAIL cm_busy_done got=%b want=0", bm.cfg_busy); else n_pass++;
    n_total++; if (bm.dout !== 4'b0000) $display("FAIL cm_old1 got=%b want=0000", bm.dout); else n_pass++;
    tick();
    bm.in_valid = 0;
    n_total++; if (bm.cfg_ack !== 1'b0) $display("FAIL cm_ack_pulse got=%b want=0", bm.cfg_ack); else n_pass++;
    n_total++; if (bm.dout !== 4'b0000) $display("FAIL cm_swap_cycle_old got=%b want=0000", bm.dout); else n_pass++;
    tick();
    n_total++; if (bm.dout !== 4'b0100) $display("FAIL cm_ack_cycle_new got=%b want=0100", bm.dout); else n_pass++;
    n_total++; if (bm.cfg_err !== 1'b0) $display("FAIL cm_err got=%b want=0", bm.cfg_err); else n_pass++;
  endtask

  task automatic test_err();
    logic v; logic [3:0] q;
    bm.cfg_commit = 1;
    tick();
    bm.cfg_commit = 0;
    bm.cfg_wr = 1; bm.cfg_ch = 2'd2; bm.cfg_word = 2'd0; bm.cfg_data = 16'hFFFF;
    tick();
    bm.cfg_wr = 0;
    n_total++; if (bm.cfg_err !== 1'b1) $display("FAIL err_set got=%b want=1", bm.cfg_err); else n_pass++;
    tick(); tick();
    lookup_m(24'h001000, v, q);
    n_total++; if (q !== 4'b0000) $display("FAIL err_shadow_b1 got=%b want=0000", q); else n_pass++;
    commit_m();
    lookup_m(24'h001000, v, q);
    n_total++; if (q !== 4'b0000) $display("FAIL err_shadow_b1_again got=%b want=0000", q); else n_pass++;
    lookup_m(24'h000000, v, q);
    n_total++; if (q !== 4'b0100) $display("FAIL err_shadow_b0 got=%b want=0100", q); else n_pass++;
    n_total++; if (bm.cfg_err !== 1'b1) $display("FAIL err_sticky got=%b want=1", bm.cfg_err); else n_pass++;
  endtask

  task automatic test_safe_commit();
    bs.cfg_wr = 1; bs.cfg_ch = 2'd0; bs.cfg_word = 2'd0; bs.cfg_data = 16'h0001;
    tick();
    bs.cfg_wr = 0;
    bs.cfg_commit = 1; bs.in_valid = 1; bs.din = '0;
    tick();
    bs.cfg_commit = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++; if (bs.cfg_busy !== 1'b1) $display("FAIL safe_busy_%0d got=%b want=1", i, bs.cfg_busy); else n_pass++;
      n_total++; if (bs.cfg_ack !== 1'b0) $display("FAIL safe_noack_%0d got=%b want=0", i, bs.cfg_ack); else n_pass++;
    end
    bs.in_valid = 0;
    tick();
    n_total++; if (bs.cfg_busy !== 1'b1) $display("FAIL safe_busy_swap got=%b want=1", bs.cfg_busy); else n_pass++;
    n_total++; if (bs.cfg_ack !== 1'b0) $display("FAIL safe_ack_early got=%b want=0", bs.cfg_ack); else n_pass++;
    tick();
    n_total++; if (bs.cfg_ack !== 1'b1) $display("FAIL safe_ack got=%b want=1", bs.cfg_ack); else n_pass++;
    n_total++; if (bs.cfg_busy !== 1'b0) $display("FAIL safe_idle got=%b want=0", bs.cfg_busy); else n_pass++;
    bs.in_valid = 1; bs.din = '0;
    tick();
    bs.in_valid = 0;
    tick();
    n_total++; if (bs.dout !== 4'b0001) $display("FAIL safe_new_mask got=%b want=0001", bs.dout); else n_pass++;
  endtask

  task automatic test_reset_armed();
    logic v; logic [3:0] q;
    wr_m(2, 0, 16'h0000);
    wr_m(0, 3, 16'h0000);
    bm.cfg_commit = 1; bm.in_valid = 1; bm.din = '0;
    tick();
    bm.cfg_commit = 0; bm.in_valid = 0;
    rst_n = 0;
    #1;
    n_total++; if (bm.out_valid !== 1'b0) $display("FAIL rarm_flush got=%b want=0", bm.out_valid); else n_pass++;
    n_total++; if (bm.cfg_busy !== 1'b0) $display("FAIL rarm_busy got=%b want=0", bm.cfg_busy); else n_pass++;
    n_total++; if (bm.cfg_err !== 1'b0) $display("FAIL rarm_err got=%b want=0", bm.cfg_err); else n_pass++;
    tick();
    rst_n = 1;
    tick();
    n_total++; if (bm.cfg_ack !== 1'b0) $display("FAIL rarm_noack got=%b want=0", bm.cfg_ack); else n_pass++;
    n_total++; if (bm.out_valid !== 1'b0) $display("FAIL rarm_vld got=%b want=0", bm.out_valid); else n_pass++;
    lookup_m(24'h000000, v, q);
    n_total++; if (q !== 4'b0000) $display("FAIL rarm_act_ch2 got=%b want=0000", q); else n_pass++;
    commit_m();
    lookup_m(24'h00003F, v, q);
    n_total++; if (q !== 4'b0001) $display("FAIL rarm_shadow_init got=%b want=0001", q); else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] m_act [4];
    logic        m_v1, m_v2, iv;
    logic [3:0]  m_d1, m_d2, lk;
    logic [23:0] d;
    logic [15:0] w16;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        w16 = 16'($urandom);
        m_act[c][w*16 +: 16] = w16;
        wr_m(c, w, w16);
      end
    end
    commit_m();
    tick();
    m_v1 = 0; m_v2 = 0; m_d1 = '0; m_d2 = '0;
    for (int n = 0; n < 1000; n++) begin
      iv = 1'($urandom_range(0, 1));
      d  = 24'($urandom);
      bm.in_valid = iv; bm.din = d;
      for (int c = 0; c < 4; c++) lk[c] = m_act[c][d[c*6 +: 6]];
      tick();
      m_v2 = m_v1;
      if (m_v1) m_d2 = m_d1;
      m_v1 = iv;
      if (iv) m_d1 = lk;
      n_total++; if (bm.out_valid !== m_v2) $display("FAIL rnd_vld_%0d got=%b want=%b", n, bm.out_valid, m_v2); else n_pass++;
      if (m_v2) begin
        n_total++; if (bm.dout !== m_d2) $display("FAIL rnd_dout_%0d got=%b want=%b", n, bm.dout, m_d2); else n_pass++;
      end
    end
    bm.in_valid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_lookup();
    test_back_to_back();
    test_commit();
    test_err();
    test_safe_commit();
    test_reset_armed();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
